fwd_hazard_unit: RTL and testbench
==================================

// Module: fwd_hazard_unit
// PURPOSE
//  Parametrised forwarding + load-use hazard unit for the pipelined RISC-V core.
//  Internally tracks in-flight destinations in a FWD_DEPTH-entry shift pipeline past EX.
//  Per EX source operand: picks youngest ready producer (fwd select), or stalls until a load's data is forwardable.
//  Replaces hand-wired 2-operand MEM/WB forwarding; sits beside ID/EX, drives EX operand muxes and pipeline stall.
// PARAMETERS
//  NUM_SRC   2  source operands per EX instruction
//  ADDR_W    5  register address width
//  FWD_DEPTH 2  tracked stages after EX (1=MEM, 2=WB, ...); range 2..7
//  LOAD_LAT  1  extra stages before load data is forwardable; must be < FWD_DEPTH
//  SEL_W     $clog2(FWD_DEPTH+1)  derived, select width per operand
// PORTS
//  clk_i             in  1                clock, rising edge
//  rst_i             in  1                asynchronous reset, active-low
//  issue_valid_i     in  1                instruction leaving EX this cycle (ignored while stall_o=1)
//  issue_rd_i        in  ADDR_W           its destination
//  issue_reg_write_i in  1                it writes the register file
//  issue_mem_read_i  in  1                it is a load
//  src_valid_i       in  NUM_SRC          operand n of EX instruction is used
//  src_addr_i        in  NUM_SRC*ADDR_W   operand n address, slice [n*ADDR_W +: ADDR_W]
//  flush_i           in  1                invalidate all tracked entries
//  fwd_sel_o         out NUM_SRC*SEL_W    0=regfile, k=stage k result; slice [n*SEL_W +: SEL_W]
//  stall_o           out 1                freeze EX and earlier stages this cycle
// BEHAVIOUR
//  - State: entry[k], k=1..FWD_DEPTH: {valid, rd, rdy_cnt}; rdy_cnt width $clog2(LOAD_LAT+1).
//  - Reset (rst_i=0, async): all valid=0, rdy_cnt=0; thus stall_o=0, fwd_sel_o=0 immediately.
//  - Per posedge, priority order:
//      flush_i=1: all valid<=0 (wins over stall and issue).
//      else stall_o=1: entry[1]<=bubble (valid=0); entry[k+1]<=entry[k].
//      else: entry[1].valid<=issue_valid_i & issue_reg_write_i & (issue_rd_i!=0);
//            entry[1].rd<=issue_rd_i; entry[1].rdy_cnt<=issue_mem_read_i ? LOAD_LAT : 0;
//            entry[k+1]<=entry[k].
//      Every shift decrements rdy_cnt, saturating at 0; entry[FWD_DEPTH] retires.
//  - Combinational, per operand n:
//      match_k = src_valid_i[n] & (src_addr!=0) & entry[k].valid & entry[k].rd==src_addr.
//      m = smallest k with match_k (youngest wins). None -> sel=0, no hazard.
//      entry[m].rdy_cnt!=0 -> hazard_n=1, sel=0; else sel=m.
//  - stall_o = OR of hazard_n; not masked by flush_i (pipeline control gives flush priority).
//  - Older ready matches are ignored when the youngest match is pending (no stale forwarding).
//  - Latency: forwarding 0 cycles; classic load-use (LOAD_LAT=1) stalls exactly 1 cycle.
//  - No sequential feedback from outputs to inputs; no comb loops.
// CONFIGURATION
//  FWD_HAZARD_STATS_EN defined: adds ports
//    fwd_count_o   out 32  cycles with any nonzero operand select
//    stall_count_o out 32  cycles with stall_o=1
//    both 0 on reset, saturate at 32'hFFFF_FFFF, unaffected by flush_i.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 ALU chain: issue rd=5 wr=1; next cyc src0=5 -> sel0=1, stall=0; following cyc -> sel0=2.
//  2 Load-use: issue rd=7 load; next cyc src1=7 -> stall=1, sel1=0 one cycle; then sel1=2, stall=0.
//  3 Youngest wins: issue rd=3 twice back-to-back; then src0=3 -> sel0=1; load rd=3 younger -> stall.
//  4 x0 / unused: issue rd=0 wr=1, src0=0 -> sel0=0, stall=0; load rd=4, src_valid=0 src=4 -> no stall.
//  5 Flush: load rd=9 in entry1, src0=9 stalling, assert flush_i -> next cyc stall=0, sel0=0.
//  6 Async reset mid-op: entries valid, drop rst_i between edges -> stall_o=0, fwd_sel_o=0 without clock;
//    with FWD_HAZARD_STATS_EN: counters 0, after test 2 stall_count_o=1.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding select and load-use stall generation.
// Tracks destinations of instructions that have left EX in a FWD_DEPTH-entry
// shift pipeline (entry 1 = MEM, entry 2 = WB, ...). For each EX source
// operand the youngest matching producer is chosen; a pending load stalls.
// Optional build macro FWD_HAZARD_STATS_EN adds saturating forward/stall
// cycle counters (fwd_count_o, stall_count_o).
module fwd_hazard_unit #(
   parameter int unsigned NUM_SRC   = 2,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned FWD_DEPTH = 2,
   parameter int unsigned LOAD_LAT  = 1,
   parameter int unsigned SEL_W     = $clog2(FWD_DEPTH + 1)
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        issue_valid_i,
   input  logic [ADDR_W-1:0]           issue_rd_i,
   input  logic                        issue_reg_write_i,
   input  logic                        issue_mem_read_i,
   input  logic [NUM_SRC-1:0]          src_valid_i,
   input  logic [NUM_SRC*ADDR_W-1:0]   src_addr_i,
   input  logic                        flush_i,
   output logic [NUM_SRC*SEL_W-1:0]    fwd_sel_o,
   output logic                        stall_o
`ifdef FWD_HAZARD_STATS_EN
   ,
   output logic [31:0]                 fwd_count_o,
   output logic [31:0]                 stall_count_o
`endif
);

   // Ready countdown width; kept at least one bit so LOAD_LAT=0 still elaborates.
   localparam int unsigned CNT_W = (LOAD_LAT > 0) ? $clog2(LOAD_LAT + 1) : 1;
   localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_LAT);

   logic              valid_q [1:FWD_DEPTH];
   logic [ADDR_W-1:0] rd_q    [1:FWD_DEPTH];
   logic [CNT_W-1:0]  cnt_q   [1:FWD_DEPTH];

   logic [NUM_SRC-1:0] hazard;
   logic               found;
   logic [ADDR_W-1:0]  addr;

   function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] c);
      return (c == '0) ? '0 : c - 1'b1;
   endfunction

   // Shift the tracking pipeline; flush clears, stall inserts a bubble at entry 1.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int unsigned k = 1; k <= FWD_DEPTH; k++) begin
            valid_q[k] <= 1'b0;
            rd_q[k]    <= '0;
            cnt_q[k]   <= '0;
         end
      end else if (flush_i) begin
         for (int unsigned k = 1; k <= FWD_DEPTH; k++) begin
            valid_q[k] <= 1'b0;
         end
      end else begin
         for (int unsigned k = 2; k <= FWD_DEPTH; k++) begin
            valid_q[k] <= valid_q[k-1];
            rd_q[k]    <= rd_q[k-1];
            cnt_q[k]   <= dec_sat(cnt_q[k-1]);
         end
         if (stall_o) begin
            valid_q[1] <= 1'b0;
            rd_q[1]    <= '0;
            cnt_q[1]   <= '0;
         end else begin
            valid_q[1] <= issue_valid_i & issue_reg_write_i & (issue_rd_i != '0);
            rd_q[1]    <= issue_rd_i;
            cnt_q[1]   <= issue_mem_read_i ? LOAD_CNT : '0;
         end
      end
   end

   // Per operand: youngest match wins; a not-yet-ready youngest match stalls
   // instead of falling back to an older (stale) producer.
   always_comb begin
      hazard    = '0;
      fwd_sel_o = '0;
      found     = 1'b0;
      addr      = '0;
      for (int unsigned n = 0; n < NUM_SRC; n++) begin
         found = 1'b0;
         addr  = src_addr_i[n*ADDR_W +: ADDR_W];
         for (int unsigned k = 1; k <= FWD_DEPTH; k++) begin
            if (!found && src_valid_i[n] && (addr != '0) && valid_q[k] && (rd_q[k] == addr)) begin
               found = 1'b1;
               if (cnt_q[k] != '0) begin
                  hazard[n] = 1'b1;
               end else begin
                  fwd_sel_o[n*SEL_W +: SEL_W] = SEL_W'(k);
               end
            end
         end
      end
   end

   assign stall_o = |hazard;

`ifdef FWD_HAZARD_STATS_EN
   // Saturating cycle counters; only reset clears them.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         fwd_count_o   <= '0;
         stall_count_o <= '0;
      end else begin
         if ((fwd_sel_o != '0) && (fwd_count_o != '1)) begin
            fwd_count_o <= fwd_count_o + 32'd1;
         end
         if (stall_o && (stall_count_o != '1)) begin
            stall_count_o <= stall_count_o + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed vectors for fwd_hazard_unit at default parameters
// (NUM_SRC=2, ADDR_W=5, FWD_DEPTH=2, LOAD_LAT=1 -> SEL_W=2, fwd_sel_o is 4 bits).
// Honours FWD_HAZARD_STATS_EN when defined.
module tb_fwd_hazard_unit;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        issue_valid_i;
   logic [4:0]  issue_rd_i;
   logic        issue_reg_write_i;
   logic        issue_mem_read_i;
   logic [1:0]  src_valid_i;
   logic [9:0]  src_addr_i;
   logic        flush_i;
   logic [3:0]  fwd_sel_o;
   logic        stall_o;
`ifdef FWD_HAZARD_STATS_EN
   logic [31:0] fwd_count_o;
   logic [31:0] stall_count_o;
`endif

   int total = 0;
   int bad   = 0;

   fwd_hazard_unit #(
      .NUM_SRC  (2),
      .ADDR_W   (5),
      .FWD_DEPTH(2),
      .LOAD_LAT (1)
   ) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .issue_valid_i    (issue_valid_i),
      .issue_rd_i       (issue_rd_i),
      .issue_reg_write_i(issue_reg_write_i),
      .issue_mem_read_i (issue_mem_read_i),
      .src_valid_i      (src_valid_i),
      .src_addr_i       (src_addr_i),
      .flush_i          (flush_i),
      .fwd_sel_o        (fwd_sel_o),
      .stall_o          (stall_o)
`ifdef FWD_HAZARD_STATS_EN
      ,
      .fwd_count_o      (fwd_count_o),
      .stall_count_o    (stall_count_o)
`endif
   );

   // 10-unit clock
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic issue(input logic v, input logic [4:0] rd, input logic wr, input logic ld);
      issue_valid_i     = v;
      issue_rd_i        = rd;
      issue_reg_write_i = wr;
      issue_mem_read_i  = ld;
   endtask

   task automatic srcs(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1);
      src_valid_i = v;
      src_addr_i  = {a1, a0};
   endtask

   task automatic idle();
      issue(1'b0, 5'd0, 1'b0, 1'b0);
      srcs(2'b00, 5'd0, 5'd0);
      flush_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b0;
      idle();
      #2;
      chk("rst_stall", {31'd0, stall_o}, 32'd0);
      chk("rst_sel", {28'd0, fwd_sel_o}, 32'd0);
`ifdef FWD_HAZARD_STATS_EN
      chk("rst_fwd_cnt", fwd_count_o, 32'd0);
      chk("rst_stall_cnt", stall_count_o, 32'd0);
`endif
      #10 rst_i = 1'b1;
      step();

      // 1: ALU chain rd=5
      issue(1'b1, 5'd5, 1'b1, 1'b0);
      step();
      issue(1'b0, 5'd0, 1'b0, 1'b0);
      srcs(2'b01, 5'd5, 5'd0);
      #1;
      chk("alu_sel_mem", {28'd0, fwd_sel_o}, 32'h1);
      chk("alu_stall_mem", {31'd0, stall_o}, 32'd0);
      step();
      chk("alu_sel_wb", {28'd0, fwd_sel_o}, 32'h2);
      chk("alu_stall_wb", {31'd0, stall_o}, 32'd0);
      step();
      chk("alu_sel_retired", {28'd0, fwd_sel_o}, 32'h0);
      idle();

      // 2: load-use rd=7 on operand 1
      issue(1'b1, 5'd7, 1'b1, 1'b1);
      step();
      issue(1'b0, 5'd0, 1'b0, 1'b0);
      srcs(2'b10, 5'd0, 5'd7);
      #1;
      chk("lu_stall", {31'd0, stall_o}, 32'd1);
      chk("lu_sel_stalled", {28'd0, fwd_sel_o}, 32'h0);
      step();
      chk("lu_sel_wb", {28'd0, fwd_sel_o}, 32'h8);
      chk("lu_stall_clear", {31'd0, stall_o}, 32'd0);
      step();
`ifdef FWD_HAZARD_STATS_EN
      chk("t2_fwd_cnt", fwd_count_o, 32'd3);
      chk("t2_stall_cnt", stall_count_o, 32'd1);
`endif
      idle();
      step();

      // 3: youngest wins, and a pending younger load hides an older ready producer
      issue(1'b1, 5'd3, 1'b1, 1'b0);
      step();
      step();
      issue(1'b1, 5'd3, 1'b1, 1'b1);
      srcs(2'b01, 5'd3, 5'd0);
      #1;
      chk("yw_sel_young", {28'd0, fwd_sel_o}, 32'h1);
      step();
      issue(1'b0, 5'd0, 1'b0, 1'b0);
      #1;
      chk("yw_stall_pending", {31'd0, stall_o}, 32'd1);
      chk("yw_no_stale_sel", {28'd0, fwd_sel_o}, 32'h0);
      step();
      chk("yw_load_wb", {28'd0, fwd_sel_o}, 32'h2);
      idle();
      step();
      step();

      // 4: x0 never forwards; unused operand never stalls
      issue(1'b1, 5'd0, 1'b1, 1'b0);
      step();
      issue(1'b0, 5'd0, 1'b0, 1'b0);
      srcs(2'b01, 5'd0, 5'd0);
      #1;
      chk("x0_sel", {28'd0, fwd_sel_o}, 32'h0);
      chk("x0_stall", {31'd0, stall_o}, 32'd0);
      issue(1'b1, 5'd4, 1'b1, 1'b1);
      srcs(2'b00, 5'd0, 5'd0);
      step();
      issue(1'b0, 5'd0, 1'b0, 1'b0);
      srcs(2'b00, 5'd4, 5'd0);
      #1;
      chk("unused_stall", {31'd0, stall_o}, 32'd0);
      chk("unused_sel", {28'd0, fwd_sel_o}, 32'h0);
      srcs(2'b01, 5'd4, 5'd0);
      #1;
      chk("used_stall", {31'd0, stall_o}, 32'd1);
      idle();
      step();
      step();

      // 5: flush beats stall
      issue(1'b1, 5'd9, 1'b1, 1'b1);
      step();
      issue(1'b0, 5'd0, 1'b0, 1'b0);
      srcs(2'b01, 5'd9, 5'd0);
      #1;
      chk("fl_stall_before", {31'd0, stall_o}, 32'd1);
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      #1;
      chk("fl_stall_after", {31'd0, stall_o}, 32'd0);
      chk("fl_sel_after", {28'd0, fwd_sel_o}, 32'h0);
      idle();
      step();

      // 6: async reset between edges
      issue(1'b1, 5'd5, 1'b1, 1'b0);
      step();
      issue(1'b0, 5'd0, 1'b0, 1'b0);
      srcs(2'b01, 5'd5, 5'd0);
      #1;
      chk("ar_sel_before", {28'd0, fwd_sel_o}, 32'h1);
      rst_i = 1'b0;
      #1;
      chk("ar_sel_reset", {28'd0, fwd_sel_o}, 32'h0);
      chk("ar_stall_reset", {31'd0, stall_o}, 32'd0);
`ifdef FWD_HAZARD_STATS_EN
      chk("ar_fwd_cnt", fwd_count_o, 32'd0);
      chk("ar_stall_cnt", stall_count_o, 32'd0);
`endif
      #1;
      rst_i = 1'b1;
      step();
      chk("ar_sel_post", {28'd0, fwd_sel_o}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
